div_seq_n: RTL

Sequential n-bit restoring divider with signed/unsigned modes. It iterates one quotient bit per cycle using an (n+1)-bit trial subtraction, the same complement-and-add arithmetic as the library subtractor. It sits downstream of the subtract stage in the arithmetic datapath. A start/busy/done handshake frames each operation, and results are held until the next completion.

---
 rtl/div_seq_n_if.sv | 26 ++
 rtl/div_seq_n.sv | 139 +++++++++++++
 2 files changed

// File: rtl/div_seq_n_if.sv
// Request/result bundle for div_seq_n: start/busy/done handshake, operands in,
// registered quotient/remainder and status flags out.
interface div_seq_n_if #(
   parameter int N = 8
) ();
   logic         start_i;
   logic         sign_i;
   logic [N-1:0] data0_i;
   logic [N-1:0] data1_i;
   logic         busy_o;
   logic         done_o;
   logic [N-1:0] quot_o;
   logic [N-1:0] rem_o;
   logic         dz_o;
   logic         over_o;

   modport master (
      output start_i, sign_i, data0_i, data1_i,
      input  busy_o, done_o, quot_o, rem_o, dz_o, over_o
   );

   modport slave (
      input  start_i, sign_i, data0_i, data1_i,
      output busy_o, done_o, quot_o, rem_o, dz_o, over_o
   );
endinterface

// File: rtl/div_seq_n.sv
// Sequential N-bit restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero short-circuits straight to DONE; results hold until the next load.
module div_seq_n #(
   parameter int N = 8
) (
   input logic        clk_i,
   input logic        rst_i,
   div_seq_n_if.slave bus
);

   localparam int CW = $clog2(N);
   localparam logic [N:0]   ONE_W   = (N+1)'(1);
   localparam logic [N-1:0] MSB_PAT = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t        state_q, state_d;
   logic [N:0]    r_q, r_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  d_q, d_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic          ovf_q, ovf_d;
   logic [N-1:0]  quot_q, quot_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dz_q, dz_d;
   logic          over_q, over_d;

   logic [N-1:0]  mag0, mag1;
   logic [N:0]    rs, t;

   // NOTE: every variable gets a default at the top of the block, so no path
   // can leave one unassigned and infer a latch.
   always_comb begin
      mag0    = (bus.sign_i && bus.data0_i[N-1]) ? -bus.data0_i : bus.data0_i;
      mag1    = (bus.sign_i && bus.data1_i[N-1]) ? -bus.data1_i : bus.data1_i;
      rs      = {r_q[N-1:0], q_q[N-1]};
      t       = rs + ~{1'b0, d_q} + ONE_W;

      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      ovf_d   = ovf_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      over_d  = over_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               r_d    = '0;
               q_d    = mag0;
               d_d    = mag1;
               cnt_d  = CW'(N-1);
               qneg_d = bus.sign_i & (bus.data0_i[N-1] ^ bus.data1_i[N-1]);
               rneg_d = bus.sign_i & bus.data0_i[N-1];
               ovf_d  = bus.sign_i && (bus.data0_i == MSB_PAT) && (bus.data1_i == '1);
               if (bus.data1_i == '0) begin
                  quot_d  = '1;
                  rem_d   = bus.data0_i;
                  dz_d    = 1'b1;
                  over_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            // Borrow out of the (N+1)-bit trial means the divisor did not fit: restore.
            if (!t[N]) begin
               r_d = t;
               q_d = {q_q[N-2:0], 1'b1};
            end else begin
               r_d = rs;
               q_d = {q_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            // The MIN / -1 case needs no special arithmetic: negating 2^(N-1) wraps to itself.
            quot_d  = qneg_q ? -q_q : q_q;
            rem_d   = rneg_q ? -r_q[N-1:0] : r_q[N-1:0];
            dz_d    = 1'b0;
            over_d  = ovf_q;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples its pre-edge value, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         ovf_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         ovf_q   <= ovf_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         over_q  <= over_d;
      end
   end

   assign bus.busy_o = (state_q != IDLE);
   assign bus.done_o = (state_q == DONE);
   assign bus.quot_o = quot_q;
   assign bus.rem_o  = rem_q;
   assign bus.dz_o   = dz_q;
   assign bus.over_o = over_q;

endmodule
